dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory (one read *or* one write per cycle, combinational read, write on the clock edge) between the processor core (port 0) and an auxiliary master such as a loader or DMA engine (port 1). Each cycle it grants at most one request, drives the memory's write-enable, address and write-data, and returns read data to the winner through a registered response. It sits directly between the requesters and the data memory, and is the only driver of the memory's control inputs.

## Interface

Parameters:
- W, 8: data width; must match the data memory.
- A, 8: address width; must match the data memory.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Req0 / Req1  in  1  request valid; held until granted.
- We0 / We1  in  1  1 = write, 0 = read; qualified by Req.
- Lock0 / Lock1  in  1  keep the grant for the next request from this port (burst).
- Addr0 / Addr1  in  A  request address.
- Wdata0 / Wdata1  in  W  write data.
- Gnt0 / Gnt1  out  1  request accepted this cycle (combinational).
- Rvalid0 / Rvalid1  out  1  read data valid, one-cycle pulse.
- Rdata0 / Rdata1  out  W  registered read data; holds its value until the next read by that port.
- WriteEn  out  1  to the memory's write enable.
- DataAddress  out  A  to the memory's address.
- DataIn  out  W  to the memory's write data.
- DataOut  in  W  from the memory's combinational read data.

## Operation

- State:
  - LastGnt: 1 bit, the last port granted. Resets to 1, so port 0 wins the first tie.
  - LockOwner: 2 bits, one-hot or zero. Resets to 0.
- Grant selection, in priority order:
  1. If LockOwner names port p and Reqp=1, grant p.
  2. Otherwise, if only one Req is high, grant that port.
  3. Otherwise, if both are high: with RR=1, grant the port that is not LastGnt; with RR=0, grant port 0.
  4. If no Req is high, grant nothing.
- Lock handling:
  - A port granted with its Lock high becomes LockOwner.
  - LockOwner clears on any cycle where the owner is granted with Lock low.
  - LockOwner also clears on any cycle where the owner has Req low; the other port may then be granted that same cycle.
- Handshake:
  - A request is accepted in exactly the cycle its Gnt is high.
  - A requester must hold Req, We, Addr and Wdata stable until it sees Gnt.
  - The arbiter never drops an accepted request.
- Memory drive in the grant cycle:
  - DataAddress = the winner's Addr.
  - DataIn = the winner's Wdata.
  - WriteEn = the winner's We.
- Memory drive when idle: WriteEn=0, DataAddress=0, DataIn=0.
- Reads: the winner's Rdata is loaded with DataOut at the edge ending the grant cycle, and its Rvalid is high for the following cycle.
- Writes: commit at the edge ending the grant cycle. A write produces no Rvalid.
- LastGnt updates to the winner on every grant; it is unchanged on idle cycles.

## Timing

- Grant: combinational, same cycle as the request, provided the port wins.
- Read latency: 1 cycle from grant to Rvalid. Back-to-back reads from one port give Rvalid on consecutive cycles.
- Throughput: 1 access per cycle in total. Two continuously requesting ports alternate under RR=1, with no starvation unless a port holds Lock.
- Write then read of the same address by any port in the next cycle returns the new data.
- Simultaneous write (port 0) and read (port 1) of the same address are serialized in grant order:
  - if the write wins, the read returns the new data one cycle later;
  - if the read wins, it returns the old data.
- Reset, synchronous, takes precedence over everything in the cycle it is asserted:
  - forces Gnt0=Gnt1=0, WriteEn=0, DataAddress=0, DataIn=0;
  - at the edge, Rvalid0/1 become 0, Rdata0/1 become 0, LastGnt becomes 1, LockOwner becomes 0.
- Reset asserted during a grant cycle: no write commits, and a pending Rvalid is suppressed.
- Rvalid from a read granted before Reset must not appear after Reset.

## Test plan

- Reset, then idle: all outputs are 0 and WriteEn stays 0 for 10 cycles.
- Port 0 writes 0x5A to address 0x10, then reads 0x10: Gnt0 is high in both cycles, and the cycle after the read shows Rvalid0=1 and Rdata0=0x5A. Port 1 sees no Rvalid.
- Both ports read continuously with RR=1: grants alternate 0,1,0,1 starting with port 0, and each port sees Rvalid every other cycle. With RR=0, only port 0 is granted while Req0 stays high.
- Same-cycle conflict: port 0 writes 0x33 and port 1 reads address 0x20, which holds 0x11, with LastGnt=1. Port 0 wins; port 1 is granted next cycle and returns Rdata1=0x33.
- Lock burst: port 1 asserts Lock for 4 reads at addresses 0x00–0x03 while Req0 is held high. Port 1 gets 4 consecutive grants, then Gnt0 goes high on the cycle after port 1's final unlocked grant.
- Reset mid-read: a grant to a port 0 read in cycle N with Reset high in cycle N gives Rvalid0=0 in cycle N+1, no write commit, and LastGnt=1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signals shared by the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
);
  logic         Req0;
  logic         Req1;
  logic         We0;
  logic         We1;
  logic         Lock0;
  logic         Lock1;
  logic [A-1:0] Addr0;
  logic [A-1:0] Addr1;
  logic [W-1:0] Wdata0;
  logic [W-1:0] Wdata1;
  logic         Gnt0;
  logic         Gnt1;
  logic         Rvalid0;
  logic         Rvalid1;
  logic [W-1:0] Rdata0;
  logic [W-1:0] Rdata1;
  logic         WriteEn;
  logic [A-1:0] DataAddress;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;

  // Arbiter side: sees requests and memory read data, drives grants, responses and memory controls.
  modport slave (
    input  Req0, Req1, We0, We1, Lock0, Lock1, Addr0, Addr1, Wdata0, Wdata1, DataOut,
    output Gnt0, Gnt1, Rvalid0, Rvalid1, Rdata0, Rdata1, WriteEn, DataAddress, DataIn
  );

  // Environment side: the two requesters plus the data memory.
  modport master (
    output Req0, Req1, We0, We1, Lock0, Lock1, Addr0, Addr1, Wdata0, Wdata1, DataOut,
    input  Gnt0, Gnt1, Rvalid0, Rvalid1, Rdata0, Rdata1, WriteEn, DataAddress, DataIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: combinational grant and
// memory drive, registered per-port read response, optional burst lock.
module dmem_arbiter #(
  parameter int unsigned W  = 8,
  parameter int unsigned A  = 8,
  parameter bit          RR = 1'b1
) (
  input logic           Clk,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);

  logic         last_gnt;
  logic         last_gnt_next;
  logic [1:0]   lock_owner;
  logic [1:0]   lock_owner_next;
  logic         gnt0;
  logic         gnt1;
  logic         rvalid0;
  logic         rvalid1;
  logic [W-1:0] rdata0;
  logic [W-1:0] rdata1;

  // Grant selection: live lock owner first, then a lone requester, then tie-break.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Reset) begin
      if (lock_owner[0] && bus.Req0) begin
        gnt0 = 1'b1;
      end else if (lock_owner[1] && bus.Req1) begin
        gnt1 = 1'b1;
      end else if (bus.Req0 && bus.Req1) begin
        if (RR && !last_gnt) gnt1 = 1'b1;
        else                 gnt0 = 1'b1;
      end else if (bus.Req0) begin
        gnt0 = 1'b1;
      end else if (bus.Req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory controls follow the winner; all zero when nobody is granted.
  always_comb begin
    bus.WriteEn     = 1'b0;
    bus.DataAddress = '0;
    bus.DataIn      = '0;
    if (gnt0) begin
      bus.WriteEn     = bus.We0;
      bus.DataAddress = bus.Addr0;
      bus.DataIn      = bus.Wdata0;
    end else if (gnt1) begin
      bus.WriteEn     = bus.We1;
      bus.DataAddress = bus.Addr1;
      bus.DataIn      = bus.Wdata1;
    end
  end

  // Next arbitration state; an idle cycle means any owner has dropped Req, so the lock clears.
  always_comb begin
    last_gnt_next   = last_gnt;
    lock_owner_next = lock_owner;
    if (gnt0) begin
      last_gnt_next   = 1'b0;
      lock_owner_next = bus.Lock0 ? 2'b01 : 2'b00;
    end else if (gnt1) begin
      last_gnt_next   = 1'b1;
      lock_owner_next = bus.Lock1 ? 2'b10 : 2'b00;
    end else begin
      lock_owner_next = 2'b00;
    end
  end

  // Arbitration state and registered read responses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_gnt   <= 1'b1;
      lock_owner <= 2'b00;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      last_gnt   <= last_gnt_next;
      lock_owner <= lock_owner_next;
      rvalid0    <= gnt0 && !bus.We0;
      rvalid1    <= gnt1 && !bus.We1;
      if (gnt0 && !bus.We0) rdata0 <= bus.DataOut;
      if (gnt1 && !bus.We1) rdata1 <= bus.DataOut;
    end
  end

  assign bus.Gnt0    = gnt0;
  assign bus.Gnt1    = gnt1;
  assign bus.Rvalid0 = rvalid0;
  assign bus.Rvalid1 = rvalid1;
  assign bus.Rdata0  = rdata0;
  assign bus.Rdata1  = rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a port-indexed reference model with its own copy of memory.
module tb_dmem_arbiter;

  localparam int unsigned W     = 8;
  localparam int unsigned A     = 8;
  localparam int unsigned DEPTH = 1 << A;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.W(W), .A(A)) bus ();
  dmem_arbiter_if #(.W(W), .A(A)) fp_bus ();

  dmem_arbiter #(.W(W), .A(A), .RR(1'b1)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  dmem_arbiter #(.W(W), .A(A), .RR(1'b0)) dut_fp (
    .Clk   (clk),
    .Reset (reset),
    .bus   (fp_bus)
  );

  // Requester stimulus, indexed by port.
  logic         r_req   [2];
  logic         r_we    [2];
  logic         r_lock  [2];
  logic [A-1:0] r_addr  [2];
  logic [W-1:0] r_wdata [2];
  logic         pending [2];

  assign bus.Req0   = r_req[0];
  assign bus.Req1   = r_req[1];
  assign bus.We0    = r_we[0];
  assign bus.We1    = r_we[1];
  assign bus.Lock0  = r_lock[0];
  assign bus.Lock1  = r_lock[1];
  assign bus.Addr0  = r_addr[0];
  assign bus.Addr1  = r_addr[1];
  assign bus.Wdata0 = r_wdata[0];
  assign bus.Wdata1 = r_wdata[1];

  assign fp_bus.Req0    = r_req[0];
  assign fp_bus.Req1    = r_req[1];
  assign fp_bus.We0     = r_we[0];
  assign fp_bus.We1     = r_we[1];
  assign fp_bus.Lock0   = r_lock[0];
  assign fp_bus.Lock1   = r_lock[1];
  assign fp_bus.Addr0   = r_addr[0];
  assign fp_bus.Addr1   = r_addr[1];
  assign fp_bus.Wdata0  = r_wdata[0];
  assign fp_bus.Wdata1  = r_wdata[1];
  assign fp_bus.DataOut = '0;

  // Data memory driven only by the arbiter under test.
  logic [W-1:0] env_mem [DEPTH];

  function automatic logic [W-1:0] init_val(int i);
    return W'(i * 37 + 11);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) env_mem[i] <= init_val(i);
    end else if (bus.WriteEn) begin
      env_mem[bus.DataAddress] <= bus.DataIn;
    end
  end

  assign bus.DataOut = env_mem[bus.DataAddress];

  // Reference model state.
  logic [W-1:0] ref_mem [DEPTH];
  int           m_last;
  int           m_owner;
  logic         m_rv [2];
  logic [W-1:0] m_rd [2];
  bit           chk_fp;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner under the stated rules: -1 for none, else the port number.
  function automatic int model_winner();
    int n;
    if (reset) return -1;
    if (m_owner >= 0 && r_req[m_owner]) return m_owner;
    n = int'(r_req[0]) + int'(r_req[1]);
    if (n == 0) return -1;
    if (n == 1) return r_req[0] ? 0 : 1;
    return 1 - m_last;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered responses just after the edge.
  task automatic cycle();
    int win;
    logic fp0, fp1;
    @(negedge clk);
    win = model_winner();
    check("gnt0", 32'(bus.Gnt0), 32'(win == 0));
    check("gnt1", 32'(bus.Gnt1), 32'(win == 1));
    check("write_en",  32'(bus.WriteEn),     (win >= 0) ? 32'(r_we[win])    : 32'd0);
    check("data_addr", 32'(bus.DataAddress), (win >= 0) ? 32'(r_addr[win])  : 32'd0);
    check("data_in",   32'(bus.DataIn),      (win >= 0) ? 32'(r_wdata[win]) : 32'd0);
    if (chk_fp) begin
      fp0 = !reset && r_req[0];
      fp1 = !reset && !r_req[0] && r_req[1];
      check("fp_gnt0", 32'(fp_bus.Gnt0), 32'(fp0));
      check("fp_gnt1", 32'(fp_bus.Gnt1), 32'(fp1));
    end
    if (reset) begin
      m_last  = 1;
      m_owner = -1;
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = 1'b0;
        m_rd[p] = '0;
      end
    end else begin
      m_rv[0] = 1'b0;
      m_rv[1] = 1'b0;
      if (win >= 0) begin
        if (r_we[win]) begin
          ref_mem[r_addr[win]] = r_wdata[win];
        end else begin
          m_rv[win] = 1'b1;
          m_rd[win] = ref_mem[r_addr[win]];
        end
        m_last       = win;
        m_owner      = r_lock[win] ? win : -1;
        pending[win] = 1'b0;
      end else begin
        m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
    check("rvalid0", 32'(bus.Rvalid0), 32'(m_rv[0]));
    check("rvalid1", 32'(bus.Rvalid1), 32'(m_rv[1]));
    check("rdata0",  32'(bus.Rdata0),  32'(m_rd[0]));
    check("rdata1",  32'(bus.Rdata1),  32'(m_rd[1]));
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic lock,
                          input logic [A-1:0] addr, input logic [W-1:0] wdata);
    r_req[p]   = req;
    r_we[p]    = we;
    r_lock[p]  = lock;
    r_addr[p]  = addr;
    r_wdata[p] = wdata;
  endtask

  // Random requester: a new request only after the previous one was granted.
  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      if (!pending[p]) begin
        pending[p] = ($urandom_range(0, 99) < 70);
        set_port(p, pending[p], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 A'($urandom_range(0, 15)), W'($urandom));
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    chk_fp   = 1'b0;
    m_last   = 1;
    m_owner  = -1;
    for (int p = 0; p < 2; p++) begin
      set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
      pending[p] = 1'b0;
      m_rv[p]    = 1'b0;
      m_rd[p]    = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);

    cycle();
    mem_init = 1'b0;
    cycle();
    reset = 1'b0;

    // Idle after reset.
    repeat (10) cycle();

    // Port 0 write then read of the same address.
    set_port(0, 1'b1, 1'b1, 1'b0, A'(8'h10), W'(8'h5A));
    cycle();
    set_port(0, 1'b1, 1'b0, 1'b0, A'(8'h10), '0);
    cycle();
    check("wr_rd_rdata0", 32'(bus.Rdata0), 32'h5A);
    check("wr_rd_rvalid1", 32'(bus.Rvalid1), 32'd0);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();

    // Same-cycle conflict: preload 0x11 via port 1, then port 0 write vs port 1 read.
    set_port(1, 1'b1, 1'b1, 1'b0, A'(8'h20), W'(8'h11));
    cycle();
    set_port(0, 1'b1, 1'b1, 1'b0, A'(8'h20), W'(8'h33));
    set_port(1, 1'b1, 1'b0, 1'b0, A'(8'h20), '0);
    cycle();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    check("conflict_rdata1", 32'(bus.Rdata1), 32'h33);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();

    // Continuous reads from both ports alternate under round-robin.
    set_port(0, 1'b1, 1'b0, 1'b0, A'(8'h10), '0);
    set_port(1, 1'b1, 1'b0, 1'b0, A'(8'h20), '0);
    repeat (8) cycle();

    // Lock burst: port 1 holds the grant for four reads while port 0 waits.
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_port(1, 1'b1, 1'b0, (i < 3), A'(i), '0);
      cycle();
    end
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    check("lock_release_rdata1", 32'(bus.Rdata1), 32'(init_val(3)));

    // Reset during a read grant and during a write: nothing commits or responds.
    set_port(0, 1'b1, 1'b0, 1'b0, A'(8'h05), '0);
    reset = 1'b1;
    cycle();
    set_port(0, 1'b1, 1'b1, 1'b0, A'(8'h10), W'(8'hEE));
    cycle();
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, A'(8'h10), '0);
    set_port(1, 1'b1, 1'b0, 1'b0, A'(8'h20), '0);
    cycle();
    check("reset_no_commit", 32'(bus.Rdata0), 32'h5A);

    // Fixed-priority instance: port 0 always wins while it requests.
    chk_fp = 1'b1;
    repeat (6) cycle();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) cycle();
    chk_fp = 1'b0;
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();

    // Randomized traffic with occasional reset.
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
